// File: rtl/staggered_adder_pipe.sv
// Pipelined N-bit adder built from 4-bit carry-lookahead slices, one slice per
// stage, with operand skew and result deskew so the full-width sum emits aligned.
// Ports: clk, rst (sync, active-high); in_valid/in_ready with a, b, cin;
//        out_valid/out_ready with sum, cout; occ = operations in flight.
module staggered_adder_pipe #(
    parameter int N = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N-1:0]              a,
    input  logic [N-1:0]              b,
    input  logic                      cin,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [N-1:0]              sum,
    output logic                      cout,
    output logic [$clog2(N/4+1)-1:0]  occ
);

    localparam int STAGES = N / 4;
    localparam int OW     = $clog2(STAGES + 1);
    localparam logic [OW-1:0] OCC_MAX = OW'(STAGES);

    generate
        if ((N % 4) != 0 || N < 8) begin : g_bad_n
            $error("staggered_adder_pipe: N must be a multiple of 4 and >= 8");
        end
    endgenerate

    // Returns {carry_out, sum[3:0]} using full lookahead within the slice.
    function automatic logic [4:0] cla4(
        input logic [3:0] x,
        input logic [3:0] y,
        input logic       c0
    );
        logic [3:0] p;
        logic [3:0] g;
        logic [4:0] c;
        p    = x ^ y;
        g    = x & y;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c0);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c0);
        return {c[4], p ^ c[3:0]};
    endfunction

    logic [STAGES-1:0] v_q, v_d;
    logic [STAGES-1:0] c_q, c_d;
    logic [N-1:0]      s_q [STAGES];
    logic [N-1:0]      s_d [STAGES];
    // Operand copies only needed by stages that still have a slice to feed.
    logic [N-1:0]      a_q [STAGES-1];
    logic [N-1:0]      a_d [STAGES-1];
    logic [N-1:0]      b_q [STAGES-1];
    logic [N-1:0]      b_d [STAGES-1];
    logic [OW-1:0]     occ_q, occ_d;

    logic adv;
    logic acc;
    logic emit;

    // Low slices of the last operand copy were consumed by earlier stages.
    logic unused_lo;
    assign unused_lo = ^{a_q[STAGES-2][4*(STAGES-1)-1:0],
                         b_q[STAGES-2][4*(STAGES-1)-1:0]};

    always_comb begin
        adv      = !v_q[STAGES-1] || out_ready;
        in_ready = adv && !rst;
        acc      = in_valid && in_ready;
        emit     = v_q[STAGES-1] && out_ready;
        v_d      = v_q;
        c_d      = c_q;
        s_d      = s_q;
        a_d      = a_q;
        b_d      = b_q;
        occ_d    = occ_q;
        if (adv) begin
            s_d[0] = '0;
            {c_d[0], s_d[0][3:0]} = cla4(a[3:0], b[3:0], cin);
            v_d[0] = acc;
            a_d[0] = a;
            b_d[0] = b;
            for (int k = 1; k < STAGES; k++) begin
                s_d[k] = s_q[k-1];
                {c_d[k], s_d[k][4*k +: 4]} =
                    cla4(a_q[k-1][4*k +: 4], b_q[k-1][4*k +: 4], c_q[k-1]);
                v_d[k] = v_q[k-1];
            end
            for (int k = 1; k < STAGES - 1; k++) begin
                a_d[k] = a_q[k-1];
                b_d[k] = b_q[k-1];
            end
        end
        if (acc && !emit) begin
            occ_d = occ_q + OW'(1);
        end else if (emit && !acc) begin
            occ_d = occ_q - OW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q   <= '0;
            c_q   <= '0;
            occ_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                s_q[k] <= '0;
            end
            for (int k = 0; k < STAGES - 1; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
        end else begin
            v_q   <= v_d;
            c_q   <= c_d;
            occ_q <= occ_d;
            for (int k = 0; k < STAGES; k++) begin
                s_q[k] <= s_d[k];
            end
            for (int k = 0; k < STAGES - 1; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
            end
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign sum       = s_q[STAGES-1];
    assign cout      = c_q[STAGES-1];
    assign occ       = occ_q;

    a_occ_max: assert property (@(posedge clk) disable iff (rst)
        occ_q <= OCC_MAX);

endmodule

// File: tb/tb_staggered_adder_pipe.sv
// Directed self-checking bench for staggered_adder_pipe (N=16).
// Each scenario task drives its vectors and checks inline.
module tb_staggered_adder_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] sum;
    logic        cout;
    logic [2:0]  occ;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] va [8];
    logic [15:0] vb [8];
    logic        vc [8];
    logic [15:0] es [8];
    logic        ec [8];

    staggered_adder_pipe #(.N(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .occ(occ)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        n_tests++;
        if (out_valid !== 1'b0 || sum !== 16'h0 || cout !== 1'b0 || occ !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_state: ov=%b sum=%h cout=%b occ=%0d want 0/0000/0/0",
                     out_valid, sum, cout, occ);
        end
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 0", in_ready);
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_single();
        int lat;
        a = 16'h1234; b = 16'h1111; cin = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        n_tests++;
        if (occ !== 3'd1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_accept: occ=%0d ov=%b want 1/0", occ, out_valid);
        end
        lat = 0;
        while (!out_valid && lat < 10) begin
            tick();
            lat++;
        end
        n_tests++;
        if (lat !== 3) begin
            n_fail++;
            $display("FAIL single_latency: edges after accept %0d want 3", lat);
        end
        n_tests++;
        if (sum !== 16'h2345 || cout !== 1'b0 || occ !== 3'd1) begin
            n_fail++;
            $display("FAIL single_result: sum=%h cout=%b occ=%0d want 2345/0/1",
                     sum, cout, occ);
        end
        tick();
        n_tests++;
        if (occ !== 3'd0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_drain: occ=%0d ov=%b want 0/0", occ, out_valid);
        end
    endtask

    task automatic test_carry();
        logic [15:0] ta [2];
        logic [15:0] tb [2];
        logic        tc [2];
        int          lat;
        ta = '{16'hFFFF, 16'hFFFF};
        tb = '{16'h0001, 16'h0000};
        tc = '{1'b0, 1'b1};
        for (int i = 0; i < 2; i++) begin
            a = ta[i]; b = tb[i]; cin = tc[i];
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            lat = 0;
            while (!out_valid && lat < 10) begin
                tick();
                lat++;
            end
            n_tests++;
            if (out_valid !== 1'b1 || sum !== 16'h0000 || cout !== 1'b1) begin
                n_fail++;
                $display("FAIL carry_ripple[%0d]: ov=%b sum=%h cout=%b want 1/0000/1",
                         i, out_valid, sum, cout);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int  got;
        bit  exp_ov;
        got = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            if (i < 8) begin
                a = va[i]; b = vb[i]; cin = vc[i];
                in_valid = 1'b1;
                n_tests++;
                if (in_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, in_ready);
                end
            end else begin
                in_valid = 1'b0;
            end
            tick();
            exp_ov = (i >= 3 && i < 11);
            n_tests++;
            if (out_valid !== exp_ov) begin
                n_fail++;
                $display("FAIL b2b_valid[%0d]: got %b want %b", i, out_valid, exp_ov);
            end
            if (out_valid === 1'b1 && got < 8) begin
                n_tests++;
                if (sum !== es[got] || cout !== ec[got]) begin
                    n_fail++;
                    $display("FAIL b2b_data[%0d]: sum=%h cout=%b want %h/%b",
                             got, sum, cout, es[got], ec[got]);
                end
                got++;
            end
        end
        n_tests++;
        if (got !== 8) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d results want 8", got);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a = va[i]; b = vb[i]; cin = vc[i];
            in_valid = 1'b1;
            tick();
        end
        n_tests++;
        if (occ !== 3'd4 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_full: occ=%0d ov=%b want 4/1", occ, out_valid);
        end
        a = 16'h5555; b = 16'h5555; cin = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_tests++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || sum !== es[0] ||
                cout !== ec[0] || occ !== 3'd4) begin
                n_fail++;
                $display("FAIL bp_stall[%0d]: rdy=%b ov=%b sum=%h cout=%b occ=%0d want 0/1/%h/%b/4",
                         i, in_ready, out_valid, sum, cout, occ, es[0], ec[0]);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int j = 1; j < 4; j++) begin
            tick();
            n_tests++;
            if (out_valid !== 1'b1 || sum !== es[j] || cout !== ec[j]) begin
                n_fail++;
                $display("FAIL bp_drain[%0d]: ov=%b sum=%h cout=%b want 1/%h/%b",
                         j, out_valid, sum, cout, es[j], ec[j]);
            end
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b0 || occ !== 3'd0) begin
            n_fail++;
            $display("FAIL bp_empty: ov=%b occ=%0d want 0/0", out_valid, occ);
        end
    endtask

    task automatic test_bubbles();
        bit exp_ov;
        int j;
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            a = va[i % 8]; b = vb[i % 8]; cin = vc[i % 8];
            in_valid = (i < 6) && ((i % 2) == 0);
            tick();
            j = i - 3;
            exp_ov = (j >= 0) && (j < 6) && ((j % 2) == 0);
            n_tests++;
            if (out_valid !== exp_ov) begin
                n_fail++;
                $display("FAIL bubble_valid[%0d]: got %b want %b", i, out_valid, exp_ov);
            end
            if (exp_ov) begin
                n_tests++;
                if (sum !== es[j % 8] || cout !== ec[j % 8]) begin
                    n_fail++;
                    $display("FAIL bubble_data[%0d]: sum=%h cout=%b want %h/%b",
                             j, sum, cout, es[j % 8], ec[j % 8]);
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        int lat;
        bit stale;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = va[i + 3]; b = vb[i + 3]; cin = vc[i + 3];
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        n_tests++;
        if (occ !== 3'd3) begin
            n_fail++;
            $display("FAIL rstmid_occ3: got %0d want 3", occ);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || occ !== 3'd0 || sum !== 16'h0 || cout !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_flush: ov=%b occ=%0d sum=%h cout=%b want 0/0/0000/0",
                     out_valid, occ, sum, cout);
        end
        stale = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid !== 1'b0) stale = 1'b1;
        end
        n_tests++;
        if (stale !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_stale: stale out_valid seen %b want 0", stale);
        end
        a = 16'hABCD; b = 16'h1234; cin = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 10) begin
            tick();
            lat++;
        end
        n_tests++;
        if (lat !== 3 || sum !== 16'hBE01 || cout !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_after: lat=%0d sum=%h cout=%b want 3/be01/0",
                     lat, sum, cout);
        end
        tick();
    endtask

    initial begin
        va = '{16'h0001, 16'h8000, 16'h00FF, 16'hABCD,
               16'hFFFF, 16'h7FFF, 16'h0F0F, 16'h1357};
        vb = '{16'h0002, 16'h8000, 16'h0001, 16'h1234,
               16'hFFFF, 16'h0001, 16'hF0F0, 16'h2468};
        vc = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        es = '{16'h0003, 16'h0000, 16'h0101, 16'hBE01,
               16'hFFFF, 16'h8000, 16'h0000, 16'h37BF};
        ec = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        test_reset();
        test_single();
        test_carry();
        test_back_to_back();
        test_backpressure();
        test_bubbles();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/staggered_adder_pipe.md
Name: staggered_adder_pipe

Overview:
- Pipelined wide adder of N bits, built as a chain of 4-bit carry-lookahead slices.
- Adds one slice per stage. The carry is registered between stages.
- Upper operand slices are skewed forward, and completed lower sum slices are deskewed, so a full-width result emits aligned.
- Sits between operand producers and result consumers in the datapath, with valid/ready on both sides. Throughput is one add per cycle.

Parameters:
- N, 16, total operand width. Must be a multiple of 4 and >= 8. Elaboration error otherwise.
- STAGES, N/4 (derived localparam, not overridable), number of pipeline stages, one 4-bit slice each.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  operand transfer request
- in_ready  output  1  block can accept operands this cycle
- a  input  N  operand A
- b  input  N  operand B
- cin  input  1  carry-in to slice 0
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- sum  output  N  A+B+cin, low N bits
- cout  output  1  carry out of bit N-1
- occ  output  $clog2(STAGES+1)  number of valid operations in flight, including the held output

Behaviour:
- One clock; reset is synchronous and active-high. All state is updated on the rising edge of clk.
- Reset values:
  - All stage valid bits 0; out_valid 0.
  - sum 0, cout 0, occ 0.
  - All data/carry registers 0.
  - in_ready is forced 0 while rst is high.
- Global enable: adv = !out_valid_reg || out_ready. When adv=0, every stage register holds, including data, carry and valid.
- in_ready = adv && !rst (combinational). Input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
- Stage k (k = 0..STAGES-1), on adv:
  - Computes slice k of a+b plus the stage carry, using lookahead within the 4 bits: P=a^b, G=a&b, carries from G|P&C, S=P^C.
  - Stage 0 carry is cin.
  - Stage k>0 carry is the registered carry-out of stage k-1.
  - Sum bits [4k+3:4k] are written into the stage-k result register.
  - Already-computed lower sum slices are copied forward.
  - Not-yet-consumed upper operand slices of a and b are copied forward.
  - The valid bit is copied from the previous stage; stage 0 takes in_valid && in_ready.
- Output register is the last stage: sum = full aligned result, cout = carry-out of slice STAGES-1, out_valid = last-stage valid.
- Latency: operands accepted at edge t appear with out_valid=1 after edge t+STAGES-1 (visible in cycle t+STAGES). With N=16 that is 4 cycles.
- Bubbles (in_valid=0) propagate as valid=0 entries. Data in invalid entries is don't-care but must not assert out_valid.
- Stall: out_valid=1 && out_ready=0 freezes the whole pipe, and sum/cout stay stable.
- Accept and emit in the same cycle is permitted when adv=1. Sustained throughput is 1 per cycle.
- occ (registered counter):
  - Increments on input transfer only.
  - Decrements on output transfer only.
  - Unchanged when both or neither occur.
  - Never exceeds STAGES. Saturation logic is not needed, but an assertion is required.
- Reset mid-operation flushes all in-flight entries with no output. The first accept after rst deasserts behaves as from power-up.
- Wrap-around: the result is modulo 2^N. Overflow is reported only through cout. No signed-overflow flag.

Test Plan:
- Reset, then a=0x1234, b=0x1111, cin=0, out_ready=1 -> out_valid rises exactly 4 cycles after accept; sum=0x2345, cout=0; occ goes 1 after the accept edge and back to 0 after the output transfer edge.
- Full carry ripple across stages: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1. Also a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1.
- Back-to-back stream of 8 random pairs with in_valid=1 and out_ready=1 -> 8 consecutive out_valid cycles, results in order and matching a+b+cin; in_ready stays 1 throughout.
- Backpressure: fill the pipe (occ=4), then hold out_ready=0 for 5 cycles -> in_ready=0; sum/cout/out_valid are stable. Release -> results drain in order with no loss or duplication.
- Bubbles: alternate in_valid 1/0 for 6 cycles -> out_valid pattern shows the same 1/0 spacing, delayed by 4 cycles.
- Reset mid-flight: assert rst for 1 cycle with occ=3 -> next cycle out_valid=0, occ=0, sum=0, cout=0; no stale result ever appears afterwards.
